// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency meter.
package freq_meter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        GATE = 1'b1
    } state_t;

    localparam int CLK_HZ              = 50000000;
    // One-second gate on the kit clock.
    localparam int DEFAULT_GATE_CYCLES = CLK_HZ;
    localparam int DEFAULT_CNT_W       = 32;

endpackage

// File: rtl/freq_meter_if.sv
// Control/result bundle between the frequency meter and its consumer.
interface freq_meter_if #(
    parameter int CNT_W = 32
);
    logic             start;
    logic             cont;
    logic             busy;
    logic             valid;
    logic [CNT_W-1:0] count_out;
    logic             overflow;

    modport master (
        output start, cont,
        input  busy, valid, count_out, overflow
    );

    modport slave (
        input  start, cont,
        output busy, valid, count_out, overflow
    );
endinterface

// File: rtl/freq_meter_sync_edge.sv
// Synchroniser for an asynchronous level plus a rising-edge detect.
// Latency: SYNC_STAGES cycles to q_sync, rise is combinational from q_sync/prev.
// Backpressure: none, runs every cycle.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_async,
    output logic q_sync,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_async};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign q_sync = sync_q[SYNC_STAGES-1];
    assign rise   = q_sync & ~prev_q;

endmodule

// File: rtl/freq_meter.sv
// Counts rising edges of sig_in over a GATE_CYCLES window of clk.
// Latency: start accepted in cycle 0, valid pulses in cycle GATE_CYCLES+1.
// Backpressure: none; result is a one-cycle pulse and is held until the next one.
module freq_meter import freq_meter_pkg::*; #(
    parameter int GATE_CYCLES = DEFAULT_GATE_CYCLES,
    parameter int CNT_W       = DEFAULT_CNT_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sig_in,
    freq_meter_if.slave  bus
);

    localparam int            GW        = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0] GATE_LOAD = GW'(GATE_CYCLES - 1);

    state_t           state;
    logic [GW-1:0]    gate_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             ovf;
    logic             sat_now;
    logic             sig_rise;
    logic             sig_level_unused;

    // Input path runs in every state so opening the gate never fabricates an edge.
    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_async (sig_in),
        .q_sync  (sig_level_unused),
        .rise    (sig_rise)
    );

    always_comb begin
        sat_now  = 1'b0;
        cnt_next = edge_cnt;
        if (sig_rise) begin
            if (&edge_cnt) begin
                sat_now = 1'b1;
            end else begin
                cnt_next = edge_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            gate_cnt      <= '0;
            edge_cnt      <= '0;
            ovf           <= 1'b0;
            bus.busy      <= 1'b0;
            bus.valid     <= 1'b0;
            bus.count_out <= '0;
            bus.overflow  <= 1'b0;
        end else begin
            bus.valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        gate_cnt <= GATE_LOAD;
                        edge_cnt <= '0;
                        ovf      <= 1'b0;
                        bus.busy <= 1'b1;
                        state    <= GATE;
                    end
                end
                GATE: begin
                    if (gate_cnt == '0) begin
                        // Last gate cycle: this cycle's edge is folded into the result.
                        bus.count_out <= cnt_next;
                        bus.overflow  <= ovf | sat_now;
                        bus.valid     <= 1'b1;
                        if (bus.cont) begin
                            gate_cnt <= GATE_LOAD;
                            edge_cnt <= '0;
                            ovf      <= 1'b0;
                        end else begin
                            bus.busy <= 1'b0;
                            state    <= IDLE;
                        end
                    end else begin
                        gate_cnt <= gate_cnt - 1'b1;
                        edge_cnt <= cnt_next;
                        ovf      <= ovf | sat_now;
                    end
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: a 32-bit and a 4-bit instance share clk, reset and sig_in.
module tb_freq_meter;
    import freq_meter_pkg::*;

    localparam int GC = 100;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic sig_in = 1'b0;

    int total = 0;
    int bad   = 0;

    // sig_in generator: 0 = held low, 1 = held high, 2 = square wave of period per
    int sig_mode = 2;
    int per      = 4;
    int ph       = 0;

    int vn;
    int busy_low;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sig_mode == 2) begin
            ph     = (ph + 1 >= per) ? 0 : ph + 1;
            sig_in = (ph < per / 2);
        end else begin
            sig_in = (sig_mode == 1);
        end
    end

    freq_meter_if #(.CNT_W(32)) bus_a ();
    freq_meter_if #(.CNT_W(4))  bus_b ();

    freq_meter #(.GATE_CYCLES(GC), .CNT_W(32), .SYNC_STAGES(2)) dut_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_in (sig_in),
        .bus    (bus_a)
    );

    freq_meter #(.GATE_CYCLES(GC), .CNT_W(4), .SYNC_STAGES(2)) dut_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_in (sig_in),
        .bus    (bus_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void drive_start(input bit sel, input logic v);
        if (sel) bus_b.start = v;
        else     bus_a.start = v;
    endfunction

    function automatic logic get_busy(input bit sel);
        return sel ? bus_b.busy : bus_a.busy;
    endfunction

    function automatic logic get_valid(input bit sel);
        return sel ? bus_b.valid : bus_a.valid;
    endfunction

    function automatic longint get_count(input bit sel);
        return sel ? longint'(bus_b.count_out) : longint'(bus_a.count_out);
    endfunction

    function automatic longint get_ovf(input bit sel);
        return sel ? longint'(bus_b.overflow) : longint'(bus_a.overflow);
    endfunction

    // One start-triggered window; inj adds start pulses at window cycles 1, 50 and GC.
    task automatic measure(input bit sel, input string tag, input longint exp_cnt,
                           input longint exp_ovf, input bit inj);
        int busy_n = 0;
        int vidx   = 0;
        int vcnt   = 0;
        drive_start(sel, 1'b1);
        tick();
        drive_start(sel, 1'b0);
        for (int i = 1; i <= GC + 20; i++) begin
            if (get_busy(sel)) busy_n++;
            if (get_valid(sel)) begin
                vcnt++;
                if (vidx == 0) vidx = i;
            end
            drive_start(sel, inj && (i == 1 || i == 50 || i == GC));
            tick();
        end
        chk({tag, "_busy_cycles"}, busy_n, GC);
        chk({tag, "_valid_cycle"}, vidx, GC + 1);
        chk({tag, "_valid_n"}, vcnt, 1);
        chk({tag, "_count"}, get_count(sel), exp_cnt);
        chk({tag, "_ovf"}, get_ovf(sel), exp_ovf);
        chk({tag, "_idle"}, get_busy(sel), 0);
    endtask

    initial begin
        bus_a.start = 1'b0;
        bus_a.cont  = 1'b0;
        bus_b.start = 1'b0;
        bus_b.cont  = 1'b0;

        // Reset state
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_a_busy",  bus_a.busy, 0);
        chk("rst_a_valid", bus_a.valid, 0);
        chk("rst_a_count", bus_a.count_out, 0);
        chk("rst_a_ovf",   bus_a.overflow, 0);
        chk("rst_b_busy",  bus_b.busy, 0);
        chk("rst_b_valid", bus_b.valid, 0);
        chk("rst_b_count", bus_b.count_out, 0);
        chk("rst_b_ovf",   bus_b.overflow, 0);
        rst_n = 1'b1;
        repeat (5) tick();

        // Single measurement, period 4 -> 25 edges in 100 cycles
        measure(1'b0, "single", 25, 0, 1'b0);

        // Constant input: no edges, none fabricated at window entry
        sig_mode = 1;
        repeat (10) tick();
        measure(1'b0, "const_hi", 0, 0, 1'b0);
        sig_mode = 0;
        repeat (10) tick();
        measure(1'b0, "const_lo", 0, 0, 1'b0);

        // Start pulses during the window (cycles 1, 50, 100) are ignored
        sig_mode = 2;
        per      = 4;
        repeat (10) tick();
        measure(1'b0, "start_busy", 25, 0, 1'b1);

        // Continuous mode, period 10: three back-to-back windows, cont dropped in the third
        per = 10;
        repeat (30) tick();
        vn       = 0;
        busy_low = 0;
        bus_a.cont  = 1'b1;
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        for (int i = 1; i <= 3 * GC + 20; i++) begin
            if (i <= 3 * GC && !bus_a.busy) busy_low++;
            if (bus_a.valid) begin
                vn++;
                chk($sformatf("cont_valid_cycle%0d", vn), i, vn * GC + 1);
                chk($sformatf("cont_count%0d", vn), bus_a.count_out, 10);
            end
            if (i == 2 * GC + 50) bus_a.cont = 1'b0;
            tick();
        end
        chk("cont_valid_n", vn, 3);
        chk("cont_busy_low", busy_low, 0);
        chk("cont_idle", bus_a.busy, 0);

        // Reset at window cycle 60 aborts the measurement
        per = 4;
        repeat (10) tick();
        measure(1'b0, "pre_rst", 25, 0, 1'b0);
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        for (int i = 1; i < 60; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_busy",  bus_a.busy, 0);
        chk("midrst_count", bus_a.count_out, 0);
        chk("midrst_valid", bus_a.valid, 0);
        vn = 0;
        for (int i = 0; i < GC + 20; i++) begin
            if (bus_a.valid) vn++;
            tick();
        end
        chk("midrst_no_valid", vn, 0);
        chk("midrst_count_held", bus_a.count_out, 0);
        measure(1'b0, "post_rst", 25, 0, 1'b0);

        // 4-bit instance: saturation, then a clean window clears the flag
        per = 4;
        repeat (10) tick();
        measure(1'b1, "ovf_sat", 15, 1, 1'b0);
        per = 20;
        repeat (30) tick();
        measure(1'b1, "ovf_clear", 5, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
